// File: rtl/sensors_height_filter.sv
// Height filter over opposing sensor pairs: averages every valid pair, then divides the sum
// by the number of valid pairs with a bit-serial restoring divider (fixed latency).
module sensors_height_filter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PAIRS = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*PAIRS*WIDTH-1:0]   sensors,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           height,
  output logic [PAIRS-1:0]           pair_mask,
  output logic                       fault
);

  localparam int unsigned N  = 2 * PAIRS;
  localparam int unsigned SW = WIDTH + $clog2(PAIRS);
  localparam int unsigned CW = $clog2(PAIRS + 1);
  localparam int unsigned IW = $clog2(PAIRS);
  localparam int unsigned DW = $clog2(SW);

  typedef enum logic [1:0] {StIdle, StPair, StDiv, StDone} state_e;

  state_e                 state_q;
  logic [N*WIDTH-1:0]     sens_q;
  logic [SW-1:0]          sum_q;
  logic [CW-1:0]          cnt_q;
  logic [PAIRS-1:0]       mask_q;
  logic [IW-1:0]          idx_q;
  logic [DW-1:0]          dcnt_q;
  logic [CW-1:0]          rem_q;
  logic [SW-1:0]          dq_q;
  logic                   out_valid_q;
  logic [WIDTH-1:0]       height_q;
  logic [PAIRS-1:0]       pair_mask_q;
  logic                   fault_q;

  logic [WIDTH-1:0]       pa, pb;
  logic                   pv;
  logic [WIDTH:0]         avg_full;
  logic [SW-1:0]          sum_nx;
  logic [CW-1:0]          cnt_nx;
  logic [PAIRS-1:0]       mask_nx;
  logic [CW:0]            rem_sh;
  logic                   qbit;
  logic [CW-1:0]          rem_nx;
  logic [SW-1:0]          dq_nx;

  always_comb begin
    pa = '0;
    pb = '0;
    for (int unsigned p = 0; p < PAIRS; p++) begin
      if (idx_q == IW'(p)) begin
        pa = sens_q[p*WIDTH +: WIDTH];
        pb = sens_q[(p+PAIRS)*WIDTH +: WIDTH];
      end
    end
    pv       = (pa != '0) && (pb != '0);
    avg_full = ({1'b0, pa} + {1'b0, pb} + (WIDTH+1)'(1)) >> 1;
    sum_nx   = pv ? sum_q + SW'(avg_full) : sum_q;
    cnt_nx   = pv ? cnt_q + CW'(1) : cnt_q;
    mask_nx  = mask_q;
    if (pv) mask_nx[idx_q] = 1'b1;

    // Remainder stays below the divisor, so CW bits hold it; dividend and quotient share dq_q.
    rem_sh = {rem_q, dq_q[SW-1]};
    qbit   = rem_sh >= {1'b0, cnt_q};
    rem_nx = qbit ? (rem_sh[CW-1:0] - cnt_q) : rem_sh[CW-1:0];
    dq_nx  = {dq_q[SW-2:0], qbit};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      sens_q      <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      mask_q      <= '0;
      idx_q       <= '0;
      dcnt_q      <= '0;
      rem_q       <= '0;
      dq_q        <= '0;
      out_valid_q <= 1'b0;
      height_q    <= '0;
      pair_mask_q <= '0;
      fault_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            sens_q  <= sensors;
            sum_q   <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            idx_q   <= '0;
            state_q <= StPair;
          end
        end
        StPair: begin
          sum_q  <= sum_nx;
          cnt_q  <= cnt_nx;
          mask_q <= mask_nx;
          idx_q  <= idx_q + IW'(1);
          if (idx_q == IW'(PAIRS - 1)) begin
            dq_q    <= sum_nx;
            rem_q   <= '0;
            dcnt_q  <= '0;
            state_q <= StDiv;
          end
        end
        StDiv: begin
          rem_q  <= rem_nx;
          dq_q   <= dq_nx;
          dcnt_q <= dcnt_q + DW'(1);
          if (dcnt_q == DW'(SW - 1)) begin
            out_valid_q <= 1'b1;
            pair_mask_q <= mask_q;
            // No valid pair: the divider output is meaningless, so report zero with fault.
            if (cnt_q == '0) begin
              height_q <= '0;
              fault_q  <= 1'b1;
            end else begin
              height_q <= dq_nx[WIDTH-1:0];
              fault_q  <= 1'b0;
            end
            state_q <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign height    = height_q;
  assign pair_mask = pair_mask_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_sensors_height_filter.sv
// Bench for sensors_height_filter (WIDTH=8, PAIRS=2): directed vectors, random samples against
// an arithmetic model, back-pressure, mid-division reset and back-to-back issue.
module tb_sensors_height_filter;

  localparam int LAT = 11;
  localparam int ISSUE = 13;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] sensors = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  height;
  logic [1:0]  pair_mask;
  logic        fault;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0] h;
    logic [1:0] m;
    logic       f;
  } exp_t;

  always #5 clk = ~clk;

  sensors_height_filter #(.WIDTH(8), .PAIRS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sensors   (sensors),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .height    (height),
    .pair_mask (pair_mask),
    .fault     (fault)
  );

  function automatic logic [31:0] pack(input int s0, input int s1, input int s2, input int s3);
    return {8'(s3), 8'(s2), 8'(s1), 8'(s0)};
  endfunction

  // Pair p is sensors p and p+2; average rounds up, final mean truncates.
  function automatic exp_t model(input logic [31:0] s);
    exp_t e;
    int sum, cnt, a, b;
    sum = 0;
    cnt = 0;
    e = '0;
    for (int p = 0; p < 2; p++) begin
      a = int'(s[p*8 +: 8]);
      b = int'(s[(p+2)*8 +: 8]);
      if (a != 0 && b != 0) begin
        sum += (a + b + 1) / 2;
        cnt++;
        e.m[p] = 1'b1;
      end
    end
    e.f = (cnt == 0);
    e.h = (cnt == 0) ? 8'd0 : 8'(sum / cnt);
    return e;
  endfunction

  function automatic logic [31:0] rand_sensors();
    logic [31:0] s;
    for (int i = 0; i < 4; i++) begin
      s[i*8 +: 8] = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) s[i*8 +: 8] = 8'd0;
      else if ($urandom_range(0, 7) == 0) s[i*8 +: 8] = 8'd255;
    end
    return s;
  endfunction

  // Presents one sample from IDLE and returns at the first negedge where out_valid is high.
  task automatic run_sample(input logic [31:0] s, output int lat, output exp_t got);
    @(negedge clk);
    sensors  = s;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    sensors  = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 3) sensors = $urandom;
    end
    got = '{h: height, m: pair_mask, f: fault};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      sensors  = $urandom;
    end
    @(negedge clk);
    n_checks++;
    if ({out_valid, height, pair_mask, fault, in_ready} !== {1'b0, 8'd0, 2'b00, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%b h=%0d m=%b f=%b rdy=%b required 0/0/00/0/1",
               out_valid, height, pair_mask, fault, in_ready);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got rdy=%b ov=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vec [4];
    exp_t        req [4];
    exp_t        got;
    int          lat;
    vec[0] = pack(10, 20, 13, 25);     req[0] = '{h: 8'd17,  m: 2'b11, f: 1'b0};
    vec[1] = pack(0, 7, 9, 4);         req[1] = '{h: 8'd6,   m: 2'b10, f: 1'b0};
    vec[2] = pack(0, 0, 0, 0);         req[2] = '{h: 8'd0,   m: 2'b00, f: 1'b1};
    vec[3] = pack(255, 255, 255, 255); req[3] = '{h: 8'd255, m: 2'b11, f: 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_sample(vec[i], lat, got);
      n_checks++;
      if (got !== req[i]) begin
        n_fail++;
        $display("FAIL directed%0d result: got h=%0d m=%b f=%b required h=%0d m=%b f=%b",
                 i, got.h, got.m, got.f, req[i].h, req[i].m, req[i].f);
      end
      n_checks++;
      if (lat != LAT) begin
        n_fail++;
        $display("FAIL directed%0d latency: got %0d edges required %0d", i, lat, LAT);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [31:0] s;
    exp_t        got, req;
    int          lat;
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      s   = rand_sensors();
      req = model(s);
      run_sample(s, lat, got);
      n_checks++;
      if (got !== req || lat != LAT) begin
        n_fail++;
        $display("FAIL random%0d s=%h: got h=%0d m=%b f=%b lat=%0d required h=%0d m=%b f=%b lat=%0d",
                 i, s, got.h, got.m, got.f, lat, req.h, req.m, req.f, LAT);
      end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || height !== req.h || pair_mask !== req.m
          || fault !== req.f) begin
        n_fail++;
        $display("FAIL random%0d post_handshake: got ov=%b rdy=%b h=%0d m=%b f=%b required 0/1/%0d/%b/%b",
                 i, out_valid, in_ready, height, pair_mask, fault, req.h, req.m, req.f);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t got;
    int   lat;
    out_ready = 1'b0;
    run_sample(pack(10, 20, 13, 25), lat, got);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      sensors  = $urandom;
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready, height, pair_mask, fault} !== {1'b1, 1'b0, 8'd17, 2'b11, 1'b0}) begin
        n_fail++;
        $display("FAIL stall%0d: got ov=%b rdy=%b h=%0d m=%b f=%b required 1/0/17/11/0",
                 i, out_valid, in_ready, height, pair_mask, fault);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready, height} !== {1'b0, 1'b1, 8'd17}) begin
      n_fail++;
      $display("FAIL stall_release: got ov=%b rdy=%b h=%0d required 0/1/17",
               out_valid, in_ready, height);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_extra_result: got ov=%b required 0", out_valid);
    end
  endtask

  task automatic test_reset_mid_div();
    exp_t got, req;
    int   lat, seen;
    out_ready = 1'b1;
    @(negedge clk);
    sensors  = pack(0, 7, 9, 4);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, height, pair_mask, fault} !== {1'b0, 8'd0, 2'b00, 1'b0}) begin
      n_fail++;
      $display("FAIL middiv_reset: got ov=%b h=%0d m=%b f=%b required 0/0/00/0",
               out_valid, height, pair_mask, fault);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL middiv_ready: got %b required 1", in_ready);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL middiv_abandon: got %0d result cycles required 0", seen);
    end
    req = model(pack(30, 0, 40, 60));
    run_sample(pack(30, 0, 40, 60), lat, got);
    n_checks++;
    if (got !== req || lat != LAT) begin
      n_fail++;
      $display("FAIL middiv_resume: got h=%0d m=%b f=%b lat=%0d required h=%0d m=%b f=%b lat=%0d",
               got.h, got.m, got.f, lat, req.h, req.m, req.f, LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t exp_q [$];
    int   acc [$];
    exp_t e;
    int   issued, done;
    issued = 0;
    done = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 120 && done < 4; c++) begin
      @(negedge clk);
      if (out_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_unexpected: got result h=%0d required none", height);
        end else begin
          e = exp_q.pop_front();
          if ({height, pair_mask, fault} !== {e.h, e.m, e.f}) begin
            n_fail++;
            $display("FAIL b2b_result%0d: got h=%0d m=%b f=%b required h=%0d m=%b f=%b",
                     done, height, pair_mask, fault, e.h, e.m, e.f);
          end
        end
        done++;
      end
      if (in_ready && issued < 4) begin
        in_valid = 1'b1;
        sensors  = rand_sensors();
        exp_q.push_back(model(sensors));
        acc.push_back(c);
        issued++;
      end else if (in_ready) begin
        in_valid = 1'b0;
      end else begin
        sensors = $urandom;
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (done != 4) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results required 4", done);
    end
    for (int i = 1; i < acc.size(); i++) begin
      n_checks++;
      if (acc[i] - acc[i-1] != ISSUE) begin
        n_fail++;
        $display("FAIL b2b_interval%0d: got %0d cycles required %0d", i, acc[i] - acc[i-1], ISSUE);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_div();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
